// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a byte producer and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data bits,
// odd parity and stop on device clock falls, then check the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s, clk_filt, fall;
  logic [FW-1:0] filt_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg;
  logic          parity;
  logic          data_oe_n, shift_en, active, timeout;

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign active  = (state == REQ) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout = active && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign cmd.tx_ready = (state == IDLE);
  assign cmd.busy     = (state != IDLE);
  assign cmd.tx_done  = (state == DONE);
  assign cmd.tx_error = (state == ERR);

  // Input conditioning: synchronizers, then a level filter that only follows
  // the clock after it has disagreed for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      fall      <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Control state, counters and registered open-drain enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      ps2_clk_oe  <= (state_n == INHIBIT);
      ps2_data_oe <= data_oe_n;
      inh_cnt     <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
      if (!active)
        to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES - 1))
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // Payload registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (cmd.tx_valid && (state == IDLE)) begin
      shreg  <= cmd.tx_data;
      parity <= ~^cmd.tx_data;
    end else if (shift_en) begin
      shreg  <= {1'b0, shreg[7:1]};
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    data_oe_n = ps2_data_oe;
    shift_en  = 1'b0;
    case (state)
      IDLE:    if (cmd.tx_valid) state_n = INHIBIT;
      INHIBIT: if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                 state_n   = REQ;
                 data_oe_n = 1'b1;
                 bit_cnt_n = '0;
               end
      REQ:     state_n = SHIFT;
      SHIFT:   if (fall) begin
                 bit_cnt_n = bit_cnt + 1'b1;
                 if (bit_cnt < 4'd8) begin
                   data_oe_n = ~shreg[0];
                   shift_en  = 1'b1;
                 end else if (bit_cnt == 4'd8) begin
                   data_oe_n = ~parity;
                 end else begin
                   state_n = ACK;
                 end
               end
      ACK:       if (fall) state_n = data_s ? ERR : WAIT_IDLE;
      WAIT_IDLE: if (clk_filt && data_s) state_n = DONE;
      DONE:      state_n = IDLE;
      ERR:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (timeout) state_n = ERR;
    // The data line is only ever held low from the request through the parity bit.
    if (!((state_n == REQ) || (state_n == SHIFT))) data_oe_n = 1'b0;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the bus.
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TO  = 3000;
  localparam int FL  = 8;
  localparam int H   = 25;

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    bit          glitch;
    logic [10:0] frame;
    int          done;
    int          err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;

  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_run = 0, last_run = 0;
  vec_t vecs[6];

  ps2_host_tx_if cmd();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd         (cmd.slave),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low; glitch inverts the clock pad.
  assign ps2_clk_in  = (~ps2_clk_oe & dev_clk) ^ glitch;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cmd.tx_done) done_cnt++;
    if (cmd.tx_error) err_cnt++;
    if (cmd.tx_done && cmd.tx_error) both_cnt++;
    if (ps2_clk_oe) oe_run++;
    else if (oe_run != 0) begin
      last_run = oe_run;
      oe_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit poke_busy);
    @(negedge clk);
    cmd.tx_data  = d;
    cmd.tx_valid = 1'b1;
    @(negedge clk);
    cmd.tx_valid = 1'b0;
    if (poke_busy) begin
      cmd.tx_data  = 8'h00;
      cmd.tx_valid = 1'b1;
      repeat (10) @(negedge clk);
      cmd.tx_valid = 1'b0;
    end
  endtask

  task automatic wait_req(output int c0, output bit ok);
    ok = 1'b0;
    c0 = 0;
    for (int i = 0; i < INH + 200; i++) begin
      @(negedge clk);
      if (ps2_data_oe && !ps2_clk_oe) begin
        c0 = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic half(input bit g);
    for (int c = 0; c < H; c++) begin
      glitch = g && (c >= 14) && (c < 17);
      @(negedge clk);
    end
    glitch = 1'b0;
  endtask

  // Keyboard: clocks the frame, samples data at each rising edge, drives ack on fall 11.
  task automatic device(input bit ack, input bit g, input int nfall, output logic [10:0] obs);
    obs = '0;
    repeat (30) @(negedge clk);
    obs = {ps2_data_in, obs[10:1]};
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      half(g);
      dev_clk = 1'b1;
      obs = {ps2_data_in, obs[10:1]};
      if (k == nfall) return;
      half(g);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    dev_clk  = 1'b0;
    half(g);
    dev_clk  = 1'b1;
    repeat (5) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0, e0, c0;
    bit ok;
    logic [10:0] obs;
    d0 = done_cnt;
    e0 = err_cnt;
    send(v.data, v.glitch);
    wait_req(c0, ok);
    check({tag, " request"}, ok, 1);
    if (ok) begin
      device(v.ack, v.glitch, 11, obs);
      repeat (40) @(negedge clk);
      check({tag, " frame bits"}, obs, v.frame);
      check({tag, " inhibit len"}, last_run, INH);
      check({tag, " done pulses"}, done_cnt - d0, v.done);
      check({tag, " error pulses"}, err_cnt - e0, v.err);
      check({tag, " ready"}, cmd.tx_ready, 1);
      check({tag, " oe released"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ce, d0, e0;
    bit ok, seen;
    logic [10:0] obs;
    vec_t vf4;

    vecs[0] = '{data: 8'hED, ack: 1'b1, glitch: 1'b0, frame: 11'h7DA, done: 1, err: 0};
    vecs[1] = '{data: 8'h07, ack: 1'b1, glitch: 1'b0, frame: 11'h40E, done: 1, err: 0};
    vecs[2] = '{data: 8'hFF, ack: 1'b1, glitch: 1'b0, frame: 11'h7FE, done: 1, err: 0};
    vecs[3] = '{data: 8'h00, ack: 1'b1, glitch: 1'b0, frame: 11'h600, done: 1, err: 0};
    vecs[4] = '{data: 8'hED, ack: 1'b0, glitch: 1'b0, frame: 11'h7DA, done: 0, err: 1};
    vecs[5] = '{data: 8'h5A, ack: 1'b1, glitch: 1'b1, frame: 11'h6B4, done: 1, err: 0};
    vf4     = '{data: 8'hF4, ack: 1'b1, glitch: 1'b0, frame: 11'h5E8, done: 1, err: 0};

    cmd.tx_data  = 8'h00;
    cmd.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", cmd.tx_ready, 1);
    check("reset busy", cmd.busy, 0);
    check("reset oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset pulses", {cmd.tx_done, cmd.tx_error}, 2'b00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Device never clocks: the error must land exactly TO cycles after the request.
    d0 = done_cnt;
    send(8'h12, 1'b0);
    wait_req(c0, ok);
    check("timeout request", ok, 1);
    seen = 1'b0;
    ce = 0;
    for (int i = 0; i < TO + 100 && !seen; i++) begin
      @(negedge clk);
      if (cmd.tx_error) begin
        seen = 1'b1;
        ce = cyc;
      end
    end
    check("timeout seen", seen, 1);
    check("timeout cycles", ce - c0, TO);
    check("timeout data_oe", ps2_data_oe, 0);
    check("timeout no done", done_cnt - d0, 0);
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of the data bits.
    send(8'hF4, 1'b0);
    wait_req(c0, ok);
    check("midreset request", ok, 1);
    device(1'b1, 1'b0, 4, obs);
    check("midreset bit3 driven", ps2_data_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset oe async", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("midreset ready async", cmd.tx_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (50) @(negedge clk);
    check("after reset ready", cmd.tx_ready, 1);
    check("after reset busy", cmd.busy, 0);
    check("after reset pulses", {done_cnt - d0, err_cnt - e0}, 0);
    run_vec(vf4, "f4");

    check("done and error together", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter for the keyboard path. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It runs the inhibit / request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge. The bus is open-drain: this block only ever drives low, and the top level ties the output enables to tristate pads.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles from the end of inhibit to ack completion (20 ms at 50 MHz)
FILTER_LEN, 8, clk cycles a synchronized ps2_clk level must be stable before it is accepted

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high when idle and able to accept a byte
ps2_clk_in  in  1  raw PS/2 clock pad level
ps2_data_in  in  1  raw PS/2 data pad level
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low
busy  out  1  high in any state other than IDLE
tx_done  out  1  one-cycle pulse: byte acknowledged by device
tx_error  out  1  one-cycle pulse: no ack, or timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE; ps2_clk_oe=0, ps2_data_oe=0; tx_done=0, tx_error=0; busy=0; tx_ready=1; counters cleared. Bus lines are released immediately, even mid-frame.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - The filtered clock level changes only after the synchronized value differs from it for FILTER_LEN consecutive cycles.
  - fall = filtered clock 1->0 transition, one-cycle strobe.
- Handshake:
  - tx_ready = (state==IDLE).
  - Accept on tx_valid & tx_ready: latch tx_data into shift register, latch parity = ~^tx_data (odd parity).
  - tx_valid is ignored while busy.
- States:
  - IDLE -> INHIBIT on accept.
  - INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES cycles -> REQ.
  - REQ: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0. Timeout counter starts. Bit counter=0 -> SHIFT.
  - SHIFT: on each fall, drive the next bit with ps2_data_oe = ~bit.
    - Falls 1-8: data bits, LSB first.
    - Fall 9: parity bit.
    - Fall 10: ps2_data_oe=0 (stop bit, line released), then -> ACK.
  - ACK: on the next fall (11th), sample synchronized data. If 0 -> WAIT_IDLE; if 1 -> ERR.
  - WAIT_IDLE: wait until filtered clock=1 and synchronized data=1 -> DONE.
  - DONE: tx_done=1 for one cycle -> IDLE.
  - ERR: tx_error=1 for one cycle; both oe=0 -> IDLE.
- Timeout: in REQ, SHIFT, ACK or WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES -> ERR. The counter saturates and does not wrap.
- Data changes only on a fall strobe; the device samples on the rising edge, so the bit is stable for the whole clock-high phase.
- Bit counter is 4 bits and is never compared beyond 11.
- Filtered clock edges are ignored in IDLE and INHIBIT. Edges seen while inhibiting are self-generated and do not count.
- A fall and a timeout in the same cycle: the timeout wins -> ERR.
- tx_done and tx_error are never asserted in the same cycle.
- Back-to-back: tx_valid held high across DONE is accepted in the first IDLE cycle after DONE.

Test Plan:
- tx_data=0xED, device model clocks at 12.5 kHz and acks. Required:
  - ps2_clk_oe high for exactly 5000 cycles, then ps2_data_oe=1.
  - Bits observed at device rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_ready returns to 1.
- tx_data=0x07 -> parity bit 0; tx_data=0xFF and tx_data=0x00 -> parity bit 1. Device acks each; each frame yields a single tx_done.
- Device leaves data high on the 11th falling edge -> tx_error pulses once, tx_done stays 0, both oe=0, state IDLE.
- Device never clocks after the request -> tx_error exactly TIMEOUT_CYCLES cycles after REQ entry; ps2_data_oe returns to 0.
- Inject 3-cycle glitches on ps2_clk_in mid-frame (FILTER_LEN=8) -> no extra bit shifted; frame completes correctly with tx_done.
- Assert reset_n=0 asynchronously during bit 4 -> both oe drop to 0 before the next clk edge. After release: tx_ready=1, no tx_done/tx_error, and a new 0xF4 frame completes normally.
